// File: rtl/temp_sched_pkg.sv
// Shared widths, channel count and FSM encoding for the temperature sample scheduler.
package temp_sched_pkg;
    localparam int NUM_CH   = 4;
    localparam int CH_W     = 2;
    localparam int SENSOR_W = 4;
    localparam int BASE_W   = 5;
    localparam int COEF_W   = 4;
    localparam int PROD_W   = SENSOR_W + COEF_W;
    localparam int TEMP_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;
endpackage

// File: rtl/seq_mult4x4.sv
// Sequential 4x4 shift-add multiplier: start loads operands, then one shift-add per cycle, LSB first.
// done pulses during the 4th (final) step; product is complete from the following cycle.
module seq_mult4x4
    import temp_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SENSOR_W-1:0] a,
    input  logic [COEF_W-1:0]   b,
    output logic                done,
    output logic [PROD_W-1:0]   product
);
    logic [2:0]        cnt_q,    cnt_d;
    logic [PROD_W-1:0] mcand_q,  mcand_d;
    logic [COEF_W-1:0] mplier_q, mplier_d;
    logic [PROD_W-1:0] prod_q,   prod_d;

    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (start) begin
            mcand_d  = PROD_W'(a);
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = 3'd4;
        end else if (cnt_q != 3'd0) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign done    = (cnt_q == 3'd1);
    assign product = prod_q;
endmodule

// File: rtl/temp_sample_scheduler.sv
// Round-robin 4-channel sensor scheduler computing base + (sensor*coef)>>3; result 5 edges after acceptance,
// held under out_ready backpressure. Optional over-temperature alarm enabled by TEMP_SCHED_ALARM_EN.
module temp_sample_scheduler
    import temp_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   req,
    input  logic [SENSOR_W-1:0] sensor0,
    input  logic [SENSOR_W-1:0] sensor1,
    input  logic [SENSOR_W-1:0] sensor2,
    input  logic [SENSOR_W-1:0] sensor3,
    output logic [NUM_CH-1:0]   ack,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [BASE_W-1:0]   cfg_base,
    input  logic [COEF_W-1:0]   cfg_coef,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TEMP_W-1:0]   out_temp,
    output logic [CH_W-1:0]     out_ch,
    input  logic [TEMP_W-1:0]   alarm_thresh,
    output logic                out_alarm,
    output logic [NUM_CH-1:0]   alarm_sticky,
    input  logic [NUM_CH-1:0]   alarm_clr
);
`ifdef TEMP_SCHED_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d, ch_q, ch_d;
    logic [BASE_W-1:0]   base_lat_q, base_lat_d;
    logic [BASE_W-1:0]   base_q [NUM_CH];
    logic [BASE_W-1:0]   base_d [NUM_CH];
    logic [COEF_W-1:0]   coef_q [NUM_CH];
    logic [COEF_W-1:0]   coef_d [NUM_CH];
    logic [NUM_CH-1:0]   ack_q, ack_d, sticky_q, sticky_d;
    logic                out_valid_q, out_valid_d, out_alarm_q, out_alarm_d;
    logic [TEMP_W-1:0]   out_temp_q, out_temp_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;

    logic [CH_W-1:0]     grant_idx, cand;
    logic                found, accept, mul_done;
    logic [SENSOR_W-1:0] sel_sensor;
    logic [PROD_W-1:0]   product;
    logic [TEMP_W-1:0]   sum;
    logic                unused_prod_lsb;

    // Search starts one past the last granted channel.
    always_comb begin
        grant_idx = ptr_q;
        cand      = '0;
        found     = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = ptr_q + CH_W'(i);
            if (!found && req[cand]) begin
                grant_idx = cand;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        case (grant_idx)
            2'd0:    sel_sensor = sensor0;
            2'd1:    sel_sensor = sensor1;
            2'd2:    sel_sensor = sensor2;
            default: sel_sensor = sensor3;
        endcase
    end

    assign accept          = (state_q == ST_IDLE) && (|req);
    assign sum             = TEMP_W'(base_lat_q) + TEMP_W'(product[PROD_W-1:3]);
    assign unused_prod_lsb = ^product[2:0];

    seq_mult4x4 u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept),
        .a       (sel_sensor),
        .b       (coef_q[grant_idx]),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        base_lat_d  = base_lat_q;
        base_d      = base_q;
        coef_d      = coef_q;
        ack_d       = '0;
        out_valid_d = out_valid_q;
        out_temp_d  = out_temp_q;
        out_ch_d    = out_ch_q;
        out_alarm_d = out_alarm_q;
        sticky_d    = ALARM_EN ? (sticky_q & ~alarm_clr) : '0;

        if (cfg_we) begin
            base_d[cfg_ch] = cfg_base;
            coef_d[cfg_ch] = cfg_coef;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d          = ST_MUL;
                    ch_d             = grant_idx;
                    ptr_d            = grant_idx;
                    base_lat_d       = base_q[grant_idx];
                    ack_d[grant_idx] = 1'b1;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                out_temp_d  = sum;
                out_ch_d    = ch_q;
                out_alarm_d = ALARM_EN && (sum >= alarm_thresh);
            end
            default: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    if (ALARM_EN && out_alarm_q) begin
                        sticky_d[out_ch_q] = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= CH_W'(NUM_CH - 1);
            ch_q        <= '0;
            base_lat_q  <= '0;
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_temp_q  <= '0;
            out_ch_q    <= '0;
            out_alarm_q <= 1'b0;
            sticky_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                base_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            base_lat_q  <= base_lat_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_temp_q  <= out_temp_d;
            out_ch_q    <= out_ch_d;
            out_alarm_q <= out_alarm_d;
            sticky_q    <= sticky_d;
            base_q      <= base_d;
            coef_q      <= coef_d;
        end
    end

    assign ack          = ack_q;
    assign out_valid    = out_valid_q;
    assign out_temp     = out_temp_q;
    assign out_ch       = out_ch_q;
    assign out_alarm    = out_alarm_q;
    assign alarm_sticky = sticky_q;
endmodule

// File: tb/tb_temp_sample_scheduler.sv
// Directed bench for temp_sample_scheduler; drives and samples on the falling clock edge.
module tb_temp_sample_scheduler;
    logic       clk, rst_n;
    logic [3:0] req, sensor0, sensor1, sensor2, sensor3, ack;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [4:0] cfg_base;
    logic [3:0] cfg_coef;
    logic       out_valid, out_ready, out_alarm;
    logic [7:0] out_temp, alarm_thresh;
    logic [1:0] out_ch;
    logic [3:0] alarm_sticky, alarm_clr;

    int checks = 0;
    int errors = 0;

    temp_sample_scheduler dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .sensor0(sensor0), .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3),
        .ack(ack), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_base(cfg_base), .cfg_coef(cfg_coef),
        .out_valid(out_valid), .out_ready(out_ready), .out_temp(out_temp), .out_ch(out_ch),
        .alarm_thresh(alarm_thresh), .out_alarm(out_alarm),
        .alarm_sticky(alarm_sticky), .alarm_clr(alarm_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [4:0] b, input logic [3:0] c);
        cfg_we = 1'b1; cfg_ch = ch; cfg_base = b; cfg_coef = c;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic set_sensor(input logic [1:0] ch, input logic [3:0] v);
        case (ch)
            2'd0:    sensor0 = v;
            2'd1:    sensor1 = v;
            2'd2:    sensor2 = v;
            default: sensor3 = v;
        endcase
    endtask

    // Runs one conversion on a single channel and completes the output handshake.
    task automatic convert(input logic [1:0] ch, input logic [3:0] sens, output logic [3:0] ack_seen,
                           output int lat, output logic [7:0] t, output logic [1:0] c, output logic al);
        int k;
        set_sensor(ch, sens);
        req = '0;
        req[ch] = 1'b1;
        out_ready = 1'b0;
        ack_seen = '0;
        k = 0;
        while (ack_seen == 4'b0 && k < 30) begin
            @(negedge clk);
            k++;
            ack_seen = ack;
        end
        req = '0;
        k = 0;
        while (!out_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        lat = out_valid ? k : -1;
        t = out_temp; c = out_ch; al = out_alarm;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_temp !== 8'd0) begin errors++; $display("FAIL reset_temp got=%0d exp=0", out_temp); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
        checks++; if (out_alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%b exp=0", out_alarm); end
        checks++; if (alarm_sticky !== 4'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=0000", alarm_sticky); end
    endtask

    task automatic test_single();
        logic [3:0] a; int lat; logic [7:0] t; logic [1:0] c; logic al;
        cfg_write(2'd0, 5'd20, 4'd5);
        convert(2'd0, 4'd12, a, lat, t, c, al);
        checks++; if (a !== 4'b0001) begin errors++; $display("FAIL single_ack got=%b exp=0001", a); end
        checks++; if (lat != 5) begin errors++; $display("FAIL single_latency got=%0d exp=5", lat); end
        checks++; if (t !== 8'd27) begin errors++; $display("FAIL single_temp got=%0d exp=27", t); end
        checks++; if (c !== 2'd0) begin errors++; $display("FAIL single_ch got=%0d exp=0", c); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_max_values();
        logic [3:0] a; int lat; logic [7:0] t; logic [1:0] c; logic al;
        cfg_write(2'd2, 5'd31, 4'd15);
        convert(2'd2, 4'd15, a, lat, t, c, al);
        checks++; if (a !== 4'b0100) begin errors++; $display("FAIL max_ack got=%b exp=0100", a); end
        checks++; if (t !== 8'd59) begin errors++; $display("FAIL max_temp got=%0d exp=59", t); end
        checks++; if (c !== 2'd2) begin errors++; $display("FAIL max_ch got=%0d exp=2", c); end
        cfg_write(2'd2, 5'd31, 4'd0);
        convert(2'd2, 4'd15, a, lat, t, c, al);
        checks++; if (t !== 8'd31) begin errors++; $display("FAIL coef0_temp got=%0d exp=31", t); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] order [5];
        int stamp [5];
        int n, cyc;
        logic [3:0] exp_ack;
        do_reset();
        sensor0 = 4'd1; sensor1 = 4'd2; sensor2 = 4'd3; sensor3 = 4'd4;
        out_ready = 1'b1;
        req = 4'hF;
        n = 0; cyc = 0;
        while (n < 5 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (ack !== 4'b0) begin
                order[n] = ack;
                stamp[n] = cyc;
                n++;
            end
        end
        req = '0;
        checks++; if (n != 5) begin errors++; $display("FAIL rr_ack_count got=%0d exp=5", n); end
        for (int i = 0; i < n; i++) begin
            exp_ack = 4'b0001 << (i % 4);
            checks++;
            if (order[i] !== exp_ack) begin errors++; $display("FAIL rr_order[%0d] got=%b exp=%b", i, order[i], exp_ack); end
            if (i > 0) begin
                checks++;
                if (stamp[i] - stamp[i-1] != 7) begin
                    errors++; $display("FAIL rr_interval[%0d] got=%0d exp=7", i, stamp[i] - stamp[i-1]);
                end
            end
        end
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int k;
        cfg_write(2'd1, 5'd10, 4'd3);
        set_sensor(2'd1, 4'd8);
        out_ready = 1'b0;
        req = 4'b0010;
        k = 0;
        do begin @(negedge clk); k++; end while (ack === 4'b0 && k < 30);
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL bp_ack got=%b exp=0010", ack); end
        req = 4'b1000;
        k = 0;
        while (!out_valid && k < 30) begin @(negedge clk); k++; end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_temp !== 8'd13 || out_ch !== 2'd1 || ack !== 4'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got valid=%b temp=%0d ch=%0d ack=%b exp valid=1 temp=13 ch=1 ack=0000",
                         i, out_valid, out_temp, out_ch, ack);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", out_valid); end
        @(negedge clk);
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL bp_pending_ack got=%b exp=1000", ack); end
        req = '0;
        k = 0;
        while (!out_valid && k < 30) begin @(negedge clk); k++; end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_midflight_cfg();
        int k;
        logic [3:0] a; int lat; logic [7:0] t; logic [1:0] c; logic al;
        cfg_write(2'd0, 5'd20, 4'd5);
        set_sensor(2'd0, 4'd12);
        req = 4'b0001;
        k = 0;
        do begin @(negedge clk); k++; end while (ack === 4'b0 && k < 30);
        req = '0;
        cfg_write(2'd0, 5'd1, 4'd1);
        k = 0;
        while (!out_valid && k < 30) begin @(negedge clk); k++; end
        checks++; if (out_temp !== 8'd27) begin errors++; $display("FAIL midcfg_current got=%0d exp=27", out_temp); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        convert(2'd0, 4'd12, a, lat, t, c, al);
        checks++; if (t !== 8'd2) begin errors++; $display("FAIL midcfg_next got=%0d exp=2", t); end
    endtask

    task automatic test_reset_midflight();
        int k, seen;
        logic [3:0] a; int lat; logic [7:0] t; logic [1:0] c; logic al;
        cfg_write(2'd3, 5'd9, 4'd0);
        convert(2'd3, 4'd5, a, lat, t, c, al);
        checks++; if (t !== 8'd9 || c !== 2'd3) begin errors++; $display("FAIL pre_rst got temp=%0d ch=%0d exp temp=9 ch=3", t, c); end
        cfg_write(2'd1, 5'd7, 4'd1);
        set_sensor(2'd1, 4'd9);
        req = 4'b0010;
        k = 0;
        do begin @(negedge clk); k++; end while (ack === 4'b0 && k < 30);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_temp !== 8'd0 || out_ch !== 2'd0 || ack !== 4'b0 || out_alarm !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got valid=%b temp=%0d ch=%0d ack=%b alarm=%b exp all 0",
                     out_valid, out_temp, out_ch, ack, out_alarm);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || ack !== 4'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_abandon got=%0d active cycles exp=0", seen); end
        convert(2'd0, 4'd12, a, lat, t, c, al);
        checks++; if (t !== 8'd0 || lat != 5) begin errors++; $display("FAIL midrst_cal_clear got temp=%0d lat=%0d exp temp=0 lat=5", t, lat); end
    endtask

    task automatic test_alarm();
        logic [3:0] a; int lat; logic [7:0] t; logic [1:0] c; logic al;
`ifdef TEMP_SCHED_ALARM_EN
        do_reset();
        cfg_write(2'd0, 5'd20, 4'd5);
        alarm_thresh = 8'd27;
        convert(2'd0, 4'd12, a, lat, t, c, al);
        checks++; if (al !== 1'b1) begin errors++; $display("FAIL alarm_flag got=%b exp=1", al); end
        checks++; if (alarm_sticky !== 4'b0001) begin errors++; $display("FAIL alarm_sticky got=%b exp=0001", alarm_sticky); end
        alarm_clr = 4'b0001;
        @(negedge clk);
        alarm_clr = 4'b0000;
        checks++; if (alarm_sticky !== 4'b0000) begin errors++; $display("FAIL alarm_clr got=%b exp=0000", alarm_sticky); end
        alarm_thresh = 8'd28;
        convert(2'd0, 4'd12, a, lat, t, c, al);
        checks++; if (al !== 1'b0 || alarm_sticky !== 4'b0) begin errors++; $display("FAIL alarm_below got flag=%b sticky=%b exp 0,0000", al, alarm_sticky); end
        alarm_thresh = 8'hFF;
`else
        alarm_thresh = 8'd0;
        convert(2'd0, 4'd12, a, lat, t, c, al);
        checks++; if (al !== 1'b0) begin errors++; $display("FAIL alarm_off_flag got=%b exp=0", al); end
        checks++; if (alarm_sticky !== 4'b0) begin errors++; $display("FAIL alarm_off_sticky got=%b exp=0000", alarm_sticky); end
        alarm_thresh = 8'hFF;
`endif
    endtask

    initial begin
        rst_n = 1'b0; req = '0; out_ready = 1'b0;
        sensor0 = '0; sensor1 = '0; sensor2 = '0; sensor3 = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_base = '0; cfg_coef = '0;
        alarm_thresh = 8'hFF; alarm_clr = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_max_values();
        test_back_to_back();
        test_backpressure();
        test_midflight_cfg();
        test_reset_midflight();
        test_alarm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
